// File: rtl/irq_conditioner.sv
// Conditions an active-low interrupt pin for the CPU: sync, debounce, falling-edge detect, hold until ack.
// Optional assertion timeout enabled by defining IRQ_TIMEOUT_EN.
module irq_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       irq_n_i,
  input  logic       ack_i,
  output logic       irq_n_o,
  output logic       pending_o,
  output logic [7:0] dropped_o,
  output logic       timeout_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  if (DEBOUNCE_CYCLES < 1) begin : g_chk_db
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ASSERTED, HOLDOFF} state_t;

  logic          s1_q, s1_d, s2_q, s2_d, db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pending_q, pending_d;
  logic [7:0]    dropped_q, dropped_d;
  logic          fall_evt, ack_eff, consume, pend_base;

  // Debounce: the synchronised level must persist for DEBOUNCE_CYCLES before it is accepted.
  always_comb begin
    s1_d  = irq_n_i;
    s2_d  = s1_q;
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_d = s2_q;
      else                                  cnt_d = cnt_q + 1'b1;
    end
  end

  assign fall_evt = db_q & ~s2_q & (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    dropped_d = dropped_q;
    consume   = 1'b0;
    case (state_q)
      IDLE: if (fall_evt) state_d = ASSERTED;
      ASSERTED: begin
        if (ack_eff) begin
          if (HOLDOFF_CYCLES > 0) begin
            state_d = HOLDOFF;
            hold_d  = HW'(HOLDOFF_CYCLES);
          end else if (pending_q) begin
            consume = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLDOFF: begin
        hold_d = hold_q - 1'b1;
        if (hold_q == HW'(1)) begin
          if (pending_q) begin
            state_d = ASSERTED;
            consume = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A request consumed this cycle frees the slot, so a coincident event refills it rather than dropping.
    pend_base = pending_q & ~consume;
    pending_d = pend_base;
    if (fall_evt && (state_q != IDLE)) begin
      if (!pend_base)               pending_d = 1'b1;
      else if (dropped_q != 8'hFF)  dropped_d = dropped_q + 8'd1;
    end
  end

`ifdef IRQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit, timeout_q, timeout_d;

  always_comb begin
    tmo_hit   = (state_q == ASSERTED) && !ack_i && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    tmo_d     = ((state_q == ASSERTED) && !ack_i && !tmo_hit) ? tmo_q + 1'b1 : '0;
    timeout_d = timeout_q | tmo_hit;
  end

  assign ack_eff   = ack_i | tmo_hit;
  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign ack_eff   = ack_i;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      db_q      <= 1'b1;
      cnt_q     <= '0;
      state_q   <= IDLE;
      hold_q    <= '0;
      pending_q <= 1'b0;
      dropped_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
    end
  end

  assign irq_n_o   = (state_q != ASSERTED);
  assign pending_o = pending_q;
  assign dropped_o = dropped_q;

endmodule
